// File: rtl/mem_wait_ctrl_pkg.sv
// mem_wait_ctrl_pkg: shared state encoding, default widths and MMIO address for the memory wait-state controller.
package mem_wait_ctrl_pkg;
    localparam int AW_DEF          = 16;
    localparam int DW_DEF          = 16;
    localparam int DEPTH_LOG2_DEF  = 8;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;
endpackage

// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if: CPU, loader and optional MMIO (MEM_WAIT_CTRL_MMIO_EN) signals between CPU side and memory controller.
interface mem_wait_ctrl_if
    import mem_wait_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          run;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_men;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_en;
    logic          bus_err;
    logic          boot;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
`ifdef MEM_WAIT_CTRL_MMIO_EN
    logic [DW-1:0] io_out;
    logic          io_strobe;
    modport master (
        output run, cpu_addr, cpu_wdata, cpu_men, cpu_we, boot, ld_valid, ld_addr, ld_data,
        input  cpu_rdata, cpu_en, bus_err, ld_ready, io_out, io_strobe
    );
    modport slave (
        input  run, cpu_addr, cpu_wdata, cpu_men, cpu_we, boot, ld_valid, ld_addr, ld_data,
        output cpu_rdata, cpu_en, bus_err, ld_ready, io_out, io_strobe
    );
`else
    modport master (
        output run, cpu_addr, cpu_wdata, cpu_men, cpu_we, boot, ld_valid, ld_addr, ld_data,
        input  cpu_rdata, cpu_en, bus_err, ld_ready
    );
    modport slave (
        input  run, cpu_addr, cpu_wdata, cpu_men, cpu_we, boot, ld_valid, ld_addr, ld_data,
        output cpu_rdata, cpu_en, bus_err, ld_ready
    );
`endif
endinterface

// File: rtl/mem_wait_ram.sv
// mem_wait_ram: single-port synchronous word RAM; a read updates rdata_o on the enabled edge, a write leaves it alone.
module mem_wait_ram #(
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DW-1:0]         wdata_i,
    output logic [DW-1:0]         rdata_o
);
    logic [DW-1:0] mem_q [2**DEPTH_LOG2];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else rdata_q <= mem_q[addr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: CPU memory port with WAIT_CYCLES wait states, boot loader write port and sticky bus error.
// Optional MEM_WAIT_CTRL_MMIO_EN maps MMIO_ADDR to an output register with a write strobe.
module mem_wait_ctrl
    import mem_wait_ctrl_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_wait_ctrl_if.slave bus
);
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [DW-1:0] rdata_q;
    logic          ram_rd_q;
    logic          bus_err_q;
    logic [DW-1:0] ram_rdata;
    logic          in_range, ld_in_range, ld_fire, is_mmio;
    logic [DW-1:0] io_rd;
    assign in_range    = (addr_q >> DEPTH_LOG2) == '0;
    assign ld_in_range = (bus.ld_addr >> DEPTH_LOG2) == '0;
    assign bus.ld_ready = rst & bus.boot & (state_q == IDLE);
    assign ld_fire     = bus.ld_valid & bus.ld_ready;
    assign bus.cpu_en  = rst & bus.run & ~bus.boot &
                         ((state_q == DONE) | ((state_q == IDLE) & ~bus.cpu_men));
    // RAM output is shown live in DONE, then captured so it survives later RAM traffic
    assign bus.cpu_rdata = ram_rd_q ? ram_rdata : rdata_q;
    assign bus.bus_err   = bus_err_q;
`ifdef MEM_WAIT_CTRL_MMIO_EN
    logic [DW-1:0] io_out_q;
    assign is_mmio       = addr_q == AW'(MMIO_ADDR);
    assign io_rd         = io_out_q;
    assign bus.io_out    = io_out_q;
    assign bus.io_strobe = (state_q == ACCESS) & we_q & is_mmio;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) io_out_q <= '0;
        else if ((state_q == ACCESS) & we_q & is_mmio) io_out_q <= wdata_q;
    end
`else
    assign is_mmio = 1'b0;
    assign io_rd   = '0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            ram_rd_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_fire & ~ld_in_range) bus_err_q <= 1'b1;
                    if (~bus.boot & bus.cpu_men) begin
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        we_q    <= bus.cpu_we;
                        cnt_q   <= '0;
                        state_q <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'(WAIT_CYCLES - 1)) state_q <= ACCESS;
                    else cnt_q <= cnt_q + 4'd1;
                end
                ACCESS: begin
                    state_q  <= DONE;
                    ram_rd_q <= ~we_q & in_range;
                    if (~we_q & ~in_range) rdata_q <= is_mmio ? io_rd : '0;
                    if (~in_range & ~is_mmio) bus_err_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    if (ram_rd_q) begin
                        rdata_q  <= ram_rdata;
                        ram_rd_q <= 1'b0;
                    end
                end
            endcase
        end
    end
    // loader and CPU never share a cycle: boot blocks CPU acceptance in IDLE
    logic                  ram_en, ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DW-1:0]         ram_wdata;
    assign ram_en    = ld_fire ? ld_in_range : ((state_q == ACCESS) & in_range);
    assign ram_we    = ld_fire | we_q;
    assign ram_addr  = ld_fire ? bus.ld_addr[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];
    assign ram_wdata = ld_fire ? bus.ld_data : wdata_q;
    mem_wait_ram #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );
endmodule
